// File: rtl/ldpc_frame_ctrl_if.sv
// Stream bundle for the LDPC frame sequencer: serial systematic input
// (s_*) with ready/valid handshake, and the assembled codeword output (m_*)
// which carries no backpressure.
// master: the side that feeds information bits and consumes the codeword.
// slave:  the frame controller.
interface ldpc_frame_ctrl_if;
    logic s_valid;
    logic s_data;
    logic s_sof;
    logic s_ready;
    logic m_valid;
    logic m_data;
    logic m_sof;
    logic m_eof;

    modport master (
        output s_valid, s_data, s_sof,
        input  s_ready,
        input  m_valid, m_data, m_sof, m_eof
    );

    modport slave (
        input  s_valid, s_data, s_sof,
        output s_ready,
        output m_valid, m_data, m_sof, m_eof
    );
endinterface

// File: rtl/ldpc_frame_ctrl.sv
// LDPC frame sequencer sitting directly upstream of the 360-bit-parallel
// parity encoder. Feeds information bits and their index to the encoder,
// reads the parity back MSB (addr P_BITS-1) first, assembles the serial
// codeword with sof/eof, and clears the encoder accumulator between frames.
//
// Build option: define ERR_CNT_EN to add err_count, an 8-bit saturating
// count of frame_err pulses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an accepted bit with s_sof; drops others
// INFO   | accepting information bits 1..K_INFO-1
// PARITY | encoder parity readout, address P_BITS-1 down to 0
// CLEAR  | one-cycle encoder clear, then back to IDLE
module ldpc_frame_ctrl #(
    parameter int K_INFO = 4320,
    parameter int P_BITS = 360,
    parameter int CNT_W  = 13,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    ldpc_frame_ctrl_if.slave  sif,
    output logic              enc_din_valid,
    output logic              enc_din,
    output logic [CNT_W-1:0]  enc_counter,
    output logic [ADDR_W-1:0] enc_out_addr,
    output logic              enc_check,
    output logic              enc_clr_n,
    input  logic              enc_dout,
    output logic              busy,
    output logic              frame_err
`ifdef ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    typedef enum logic [1:0] {IDLE, INFO, PARITY, CLEAR} state_t;

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(K_INFO - 1);
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(P_BITS - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    idx, idx_n;
    logic [CNT_W-1:0]    cnt_hold;
    logic [CNT_W-1:0]    cnt_c;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic                ready;
    logic                din_valid;
    logic                check;
    logic                clr;
    logic                abort;
    logic                sof_acc;

    logic                m_valid_q;
    logic                m_data_q;
    logic                m_sof_q;
    logic                m_eof_q;
    logic                par_sel_q;

    // Next-state and encoder-side strobes; the encoder sees each bit in the
    // same cycle it is accepted, so these are combinational from the handshake.
    // rst_n gates ready/clear so the outputs go quiet the instant reset asserts.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        addr_n    = addr;
        ready     = 1'b0;
        din_valid = 1'b0;
        cnt_c     = cnt_hold;
        check     = 1'b0;
        clr       = 1'b0;
        abort     = 1'b0;
        sof_acc   = 1'b0;
        case (state)
            IDLE: begin
                ready = rst_n;
                cnt_c = '0;
                if (ready && sif.s_valid && sif.s_sof) begin
                    din_valid = 1'b1;
                    sof_acc   = 1'b1;
                    idx_n     = CNT_W'(1);
                    state_n   = INFO;
                end
            end
            INFO: begin
                ready = rst_n;
                if (ready && sif.s_valid) begin
                    if (sif.s_sof) begin
                        abort   = 1'b1;
                        state_n = CLEAR;
                    end else begin
                        din_valid = 1'b1;
                        cnt_c     = idx;
                        idx_n     = idx + CNT_W'(1);
                        if (idx == LAST_IDX) begin
                            state_n = PARITY;
                        end
                    end
                end
            end
            PARITY: begin
                check = 1'b1;
                if (addr == '0) begin
                    addr_n  = ADDR_FIRST;
                    state_n = CLEAR;
                end else begin
                    addr_n = addr - ADDR_W'(1);
                end
            end
            CLEAR: begin
                clr     = 1'b1;
                cnt_c   = '0;
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, bit index, parity address and the held encoder counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            addr     <= ADDR_FIRST;
            cnt_hold <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            addr     <= addr_n;
            cnt_hold <= cnt_c;
        end
    end

    // Codeword output stage: systematic bits are registered here, parity bits
    // come straight from the encoder's own output register one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
            par_sel_q <= 1'b0;
        end else begin
            m_valid_q <= din_valid | check;
            m_data_q  <= din_valid & sif.s_data;
            m_sof_q   <= sof_acc;
            m_eof_q   <= check & (addr == '0);
            par_sel_q <= check;
        end
    end

`ifdef ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of aborted frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (abort && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign sif.s_ready    = ready;
    assign sif.m_valid    = m_valid_q;
    assign sif.m_data     = par_sel_q ? enc_dout : m_data_q;
    assign sif.m_sof      = m_sof_q;
    assign sif.m_eof      = m_eof_q;

    assign enc_din_valid  = din_valid;
    assign enc_din        = din_valid & sif.s_data;
    assign enc_counter    = cnt_c;
    assign enc_out_addr   = addr;
    assign enc_check      = check;
    assign enc_clr_n      = rst_n & ~clr;
    assign busy           = (state != IDLE);
    assign frame_err      = abort;

endmodule

// File: doc/ldpc_frame_ctrl.md
Name: ldpc_frame_ctrl

Overview:
- Frame sequencer directly upstream of the 360-bit-parallel LDPC parity encoder.
- Accepts a serial systematic bit stream with start-of-frame marking, and drives the encoder's bit-valid, bit-index counter, parity read address and parity-output enable.
- Assembles the final serial codeword: K_INFO systematic bits followed by P_BITS parity bits, with sof/eof flags.
- Clears the encoder accumulator between frames.

Parameters:
K_INFO, 4320, information bits per frame (12 groups of 360)
P_BITS, 360, parity bits per frame
CNT_W, 13, width of encoder bit-index counter
ADDR_W, 9, width of parity read address

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input bit valid
s_data  in  1  input information bit
s_sof  in  1  marks bit 0 of a frame
s_ready  out  1  input accepted when s_valid & s_ready
enc_din_valid  out  1  encoder bit valid
enc_din  out  1  encoder information bit
enc_counter  out  CNT_W  index of bit presented to encoder
enc_out_addr  out  ADDR_W  parity bit select, P_BITS-1 down to 0
enc_check  out  1  encoder parity-output enable
enc_clr_n  out  1  active-low synchronous clear to encoder
enc_dout  in  1  encoder registered parity bit (1-cycle latency from enc_check/enc_out_addr)
m_valid  out  1  codeword bit valid (no backpressure)
m_data  out  1  codeword bit
m_sof  out  1  first codeword bit
m_eof  out  1  last codeword bit
busy  out  1  state != IDLE
frame_err  out  1  one-cycle pulse on aborted frame

Behaviour:
- Reset values (async, rst_n low): state IDLE; all outputs 0, except enc_clr_n=0 while rst_n low and enc_out_addr=P_BITS-1. enc_counter=0.
- States:
  - IDLE: s_ready=1.
    - Accepted bit with s_sof: drive enc_din_valid=1, enc_din=s_data, enc_counter=0 combinationally from the accept; go to INFO with idx=1.
    - Accepted bit without s_sof: dropped silently.
  - INFO: s_ready=1.
    - Each accepted bit: enc_din_valid=1, enc_din=s_data, enc_counter=idx, then idx++.
    - No accept: enc_din_valid=0, enc_counter holds last value.
    - Accept at idx=K_INFO-1: go to PARITY.
    - Accepted bit with s_sof at idx>0: bit dropped, no enc_din_valid, frame_err=1 for one cycle, go to CLEAR. No parity and no m_eof for the aborted frame.
  - PARITY: s_ready=0; enc_check=1; enc_out_addr starts at P_BITS-1 and decrements each cycle. Cycle with addr=0: go to CLEAR.
  - CLEAR: s_ready=0; enc_clr_n=0 for exactly one cycle; enc_counter=0; then go to IDLE.
- Output assembly:
  - Systematic bits: m_valid/m_data registered, 1 cycle after acceptance. m_sof on the idx-0 bit.
  - Parity bits: m_valid = enc_check delayed 1 cycle; m_data = enc_dout, selected directly because it is already registered.
  - Last info bit appears in the first PARITY cycle. Parity bit for addr P_BITS-1 appears in the next cycle, so the codeword is contiguous once input is contiguous.
  - m_eof is asserted with the parity bit for addr 0, in the CLEAR cycle.
- Codeword length is K_INFO+P_BITS=4680 bits. s_ready is low for P_BITS+1=361 cycles between frames.
- enc_counter never exceeds K_INFO-1. enc_din_valid and enc_check are never high together.
- In IDLE and CLEAR, enc_counter=0 so the encoder preloads generator group 0.
- Reset mid-frame: immediate return to IDLE; outputs zero; partial codeword abandoned with no m_eof.

Optional Feature:
ERR_CNT_EN:
- Defined: adds output err_count, 8 bits wide: saturating count of frame_err pulses, reset to 0, stops at 255.
- Undefined: port and counter absent; frame_err still present.

Test Plan:
- All-zero 4320-bit frame, contiguous -> 4680 m_valid bits, all 0; m_sof on bit 1; m_eof on bit 4680; enc_clr_n low exactly 1 cycle.
- Single 1 at bit 0, rest 0 -> m_data parity section equals generator group-0 row 0 as computed by the golden model, output MSB (addr 359) first.
- Random frame with s_valid gaps of 1-5 cycles -> enc_counter holds during gaps; parity matches golden model; m_valid gap pattern mirrors input.
- s_sof reasserted at bit 1000 -> frame_err pulse 1 cycle, no m_eof, enc_clr_n low 1 cycle; next full frame encodes correctly.
- rst_n low during PARITY at addr 200 -> all outputs 0 immediately, state IDLE; next frame parity correct.
- Two back-to-back frames -> s_ready low exactly 361 cycles between; second frame parity independent of first.
